// File: rtl/control_logic.sv
// control_logic: hazard/stall controller for the in-order ID -> OF -> EX pipeline.
// Compares per-stage register read/write masks in the same cycle and drives
// hold/bubble controls. It also keeps a stall-cycle counter and a sticky
// deadlock watchdog.
// Optional feature macro: CONTROL_LOGIC_FWD_EN. When it is defined, EX results
// are forwarded into OF instead of stalling on an OF/EX dependency.
module control_logic #(
    parameter int NREGS     = 16,
    parameter int CNT_W     = 32,
    parameter int MAX_STALL = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [NREGS-1:0] id_request,
    input  logic [NREGS-1:0] id_provide,
    input  logic             of_valid,
    input  logic [NREGS-1:0] of_request,
    input  logic [NREGS-1:0] of_provide,
    input  logic             ex_valid,
    input  logic [NREGS-1:0] ex_provide,
    output logic             stall_id,
    output logic             stall_of,
    output logic             bubble_of,
    output logic             bubble_ex,
    output logic [NREGS-1:0] fwd_mask,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             deadlock
);

    // The run counter only needs to reach MAX_STALL. It saturates there, so it never wraps.
    localparam int             RUN_W   = $clog2(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);

    logic [NREGS-1:0] w_id_req;
    logic [NREGS-1:0] w_of_req;
    logic [NREGS-1:0] w_of_prv;
    logic [NREGS-1:0] w_ex_prv;
    logic             w_haz_of;
    logic             w_haz_id;
    logic             w_unused;
    logic [RUN_W-1:0] r_run;

    // A stage without a real instruction contributes empty masks.
    assign w_id_req = id_valid ? id_request : '0;
    assign w_of_req = of_valid ? of_request : '0;
    assign w_of_prv = of_valid ? of_provide : '0;
    assign w_ex_prv = ex_valid ? ex_provide : '0;

    // The ID instruction's write set takes no part in any hazard.
    assign w_unused = ^id_provide;

`ifdef CONTROL_LOGIC_FWD_EN
    // EX results are bypassed into OF, so OF never waits on EX.
    // EX has written back by the time the ID instruction reaches OF.
    assign w_haz_of = 1'b0;
    assign fwd_mask = w_of_req & w_ex_prv;
    assign w_haz_id = |(w_id_req & w_of_prv);
`else
    assign w_haz_of = |(w_of_req & w_ex_prv);
    assign fwd_mask = '0;
    assign w_haz_id = |(w_id_req & (w_of_prv | w_ex_prv));
`endif

    // An OF hazard holds ID->OF, so in that case ID->OF is held and not bubbled.
    assign stall_of  = w_haz_of;
    assign bubble_ex = w_haz_of;
    assign stall_id  = w_haz_id | w_haz_of;
    assign bubble_of = w_haz_id & ~w_haz_of;

    // Stall statistics. Deadlock sets on the edge where the run reaches MAX_STALL and stays set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            r_run        <= '0;
            deadlock     <= 1'b0;
        end else if (stall_id) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
            if (r_run != RUN_MAX)
                r_run <= r_run + RUN_W'(1);
            if (r_run >= RUN_MAX - RUN_W'(1))
                deadlock <= 1'b1;
        end else begin
            r_run <= '0;
        end
    end

endmodule

// File: tb/tb_control_logic.sv
// tb_control_logic: scoreboard bench for control_logic.
// The driver applies stimulus, then pushes the reference model's expectation into a queue.
// A separate monitor pops each entry and compares it against the DUT outputs.
module tb_control_logic;

    localparam int NREGS     = 16;
    localparam int CNT_W     = 32;
    localparam int MAX_STALL = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             id_valid = 1'b0, of_valid = 1'b0, ex_valid = 1'b0;
    logic [NREGS-1:0] id_request = '0, id_provide = '0;
    logic [NREGS-1:0] of_request = '0, of_provide = '0, ex_provide = '0;
    logic             stall_id, stall_of, bubble_of, bubble_ex, deadlock;
    logic [NREGS-1:0] fwd_mask;
    logic [CNT_W-1:0] stall_cycles;

    control_logic #(.NREGS(NREGS), .CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_request(id_request), .id_provide(id_provide),
        .of_valid(of_valid), .of_request(of_request), .of_provide(of_provide),
        .ex_valid(ex_valid), .ex_provide(ex_provide),
        .stall_id(stall_id), .stall_of(stall_of), .bubble_of(bubble_of),
        .bubble_ex(bubble_ex), .fwd_mask(fwd_mask),
        .stall_cycles(stall_cycles), .deadlock(deadlock)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               idx;
        logic             sid, sof, bof, bex, dl;
        logic [NREGS-1:0] fwd;
        logic [CNT_W-1:0] sc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_push = 0;

    // Reference model state: total stalled cycles, current consecutive run, sticky flag.
    logic [CNT_W-1:0] m_sc  = '0;
    int               m_run = 0;
    logic             m_dl  = 1'b0;
    logic             m_sid_last;

    // Expected outputs for the current inputs, worked out from the spec's rules.
    task automatic push_exp();
        exp_t e;
        logic [NREGS-1:0] ir, orq, op, ep;
        logic hof, hid;
        ir  = id_valid ? id_request : 16'h0;
        orq = of_valid ? of_request : 16'h0;
        op  = of_valid ? of_provide : 16'h0;
        ep  = ex_valid ? ex_provide : 16'h0;
`ifdef CONTROL_LOGIC_FWD_EN
        hof   = 1'b0;
        hid   = (ir & op) != 0;
        e.fwd = orq & ep;
`else
        hof   = (orq & ep) != 0;
        hid   = (ir & (op | ep)) != 0;
        e.fwd = 16'h0;
`endif
        e.sof = hof;
        e.bex = hof;
        e.sid = hof || hid;
        e.bof = hid && !hof;
        e.sc  = m_sc;
        e.dl  = m_dl;
        e.idx = n_push;
        n_push++;
        m_sid_last = e.sid;
        exp_q.push_back(e);
    endtask

    // Advance the counters as the coming clock edge should.
    task automatic model_edge();
        if (reset) return;
        if (m_sid_last) begin
            m_sc  = m_sc + 1;
            m_run = m_run + 1;
            if (m_run >= MAX_STALL) m_dl = 1'b1;
        end else begin
            m_run = 0;
        end
    endtask

    task automatic drive(input logic iv, input logic [15:0] ir, input logic [15:0] ip,
                         input logic ov, input logic [15:0] orq, input logic [15:0] op,
                         input logic ev, input logic [15:0] ep);
        @(negedge clk);
        id_valid = iv; id_request = ir; id_provide = ip;
        of_valid = ov; of_request = orq; of_provide = op;
        ex_valid = ev; ex_provide = ep;
        #1 push_exp();
        model_edge();
    endtask

    // Reset is raised in mid-cycle and checked before the next edge. It is lowered at the following negedge.
    task automatic reset_pulse();
        #1 reset = 1'b1;
        m_sc = '0; m_run = 0; m_dl = 1'b0;
        #1 push_exp();
        @(negedge clk);
        reset = 1'b0;
        #1 push_exp();
        model_edge();
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s #%0d: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    // Monitor: compares each expectation as soon as the driver publishes it.
    initial begin
        exp_t e;
        forever begin
            wait (exp_q.size() != 0);
            e = exp_q.pop_front();
            chk("stall_id",     e.idx, 32'(stall_id),     32'(e.sid));
            chk("stall_of",     e.idx, 32'(stall_of),     32'(e.sof));
            chk("bubble_of",    e.idx, 32'(bubble_of),    32'(e.bof));
            chk("bubble_ex",    e.idx, 32'(bubble_ex),    32'(e.bex));
            chk("fwd_mask",     e.idx, 32'(fwd_mask),     32'(e.fwd));
            chk("stall_cycles", e.idx, stall_cycles,      e.sc);
            chk("deadlock",     e.idx, 32'(deadlock),     32'(e.dl));
        end
    end

    // Global time bound.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] rmask();
        return 16'($urandom) & 16'($urandom) & 16'($urandom);
    endfunction

    initial begin
        logic iv, ov, ev;
        logic [15:0] ir, ip, orq, op, ep;
        int rep;

        // Reset state, with the comb outputs live during reset.
        drive(1, 16'h0008, 16'h0, 1, 16'h0, 16'h0008, 1, 16'h0);
        drive(0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 0, 16'h0);
        reset = 1'b0;

        // No overlap.
        drive(1, 16'h0001, 16'h0, 1, 16'h0, 16'h0002, 1, 16'h0004);
        drive(1, 16'h0001, 16'h0, 1, 16'h0, 16'h0002, 1, 16'h0004);
        // ID/OF RAW, then a clean cycle to observe stall_cycles = 1.
        drive(1, 16'h0008, 16'h0, 1, 16'h0, 16'h0008, 1, 16'h0);
        drive(1, 16'h0001, 16'h0, 1, 16'h0, 16'h0002, 1, 16'h0004);
        // OF/EX RAW, or forwarding when the feature is on.
        drive(1, 16'h0, 16'h0, 1, 16'h0003, 16'h0, 1, 16'h0002);
        // Simultaneous ID and OF hazards.
        drive(1, 16'h0002, 16'h0, 1, 16'h0003, 16'h0, 1, 16'h0002);
        // Valid gating.
        drive(1, 16'h0008, 16'h0, 0, 16'h0, 16'h0008, 1, 16'h0);
        drive(1, 16'h0008, 16'h0, 1, 16'h0, 16'h0008, 0, 16'h0);

        // Watchdog: 8 hazard cycles, then clear the hazard. Deadlock stays set and stall_cycles = 8.
        reset_pulse();
        for (int i = 0; i < MAX_STALL; i++)
            drive(1, 16'h0008, 16'h0, 1, 16'h0, 16'h0008, 1, 16'h0);
        drive(1, 16'h0001, 16'h0, 1, 16'h0, 16'h0002, 1, 16'h0004);
        drive(1, 16'h0001, 16'h0, 1, 16'h0, 16'h0002, 1, 16'h0004);
        reset_pulse();
        // Seven stalls then a break: deadlock must not set.
        for (int i = 0; i < MAX_STALL - 1; i++)
            drive(1, 16'h0008, 16'h0, 1, 16'h0, 16'h0008, 1, 16'h0);
        drive(0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 0, 16'h0);
        drive(0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 0, 16'h0);

        // Randomized traffic, with occasional held inputs and mid-cycle resets.
        for (int n = 0; n < 500; n++) begin
            iv = ($urandom_range(0, 3) != 0); ov = ($urandom_range(0, 3) != 0);
            ev = ($urandom_range(0, 3) != 0);
            ir = rmask(); ip = rmask(); orq = rmask(); op = rmask(); ep = rmask();
            rep = ($urandom_range(0, 15) == 0) ? 10 : 1;
            for (int k = 0; k < rep; k++)
                drive(iv, ir, ip, ov, orq, op, ev, ep);
            if ($urandom_range(0, 49) == 0)
                reset_pulse();
        end

        // Drain: the monitor must have consumed everything.
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) #1;
        if (exp_q.size() != 0) begin
            n_cmp++; n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
